// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one shift-add multiplier between NUM_REQ requesters.
// Define MULT_ARB_TIMEOUT_EN to build the WAIT-state watchdog (TIMEOUT_CYCLES).
module mult_share_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned ID_W           = 2,
   parameter int unsigned TIMEOUT_CYCLES = 31
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ*8-1:0] req_a,
   input  logic [NUM_REQ*8-1:0] req_b,
   output logic [NUM_REQ-1:0]   rsp_valid,
   output logic [7:0]           rsp_data,
   output logic                 rsp_err,
   output logic [ID_W-1:0]      grant_id,
   output logic                 busy,
   output logic [7:0]           mul_a,
   output logic [7:0]           mul_b,
   output logic                 mul_start,
   input  logic                 mul_done,
   input  logic [7:0]           mul_c
);

   typedef enum logic [1:0] {StIdle, StStart, StWait, StResp} state_e;

   state_e          state_q, state_d;
   logic [7:0]      mul_a_q, mul_a_d;
   logic [7:0]      mul_b_q, mul_b_d;
   logic [7:0]      rsp_data_q, rsp_data_d;
   logic [ID_W-1:0] grant_id_q, grant_id_d;
   logic [ID_W-1:0] last_grant_q, last_grant_d;
   logic [ID_W-1:0] pick;
   logic [ID_W-1:0] scan_idx;

`ifdef MULT_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rsp_err_q, rsp_err_d;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   // Scan from the highest offset down so the nearest requester after last_grant wins.
   always_comb begin
      pick     = last_grant_q;
      scan_idx = last_grant_q;
      for (int k = NUM_REQ; k >= 1; k--) begin
         scan_idx = ID_W'((int'(last_grant_q) + k) % int'(NUM_REQ));
         if (req[scan_idx]) begin
            pick = scan_idx;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      mul_a_d      = mul_a_q;
      mul_b_d      = mul_b_q;
      rsp_data_d   = rsp_data_q;
      grant_id_d   = grant_id_q;
      last_grant_d = last_grant_q;
`ifdef MULT_ARB_TIMEOUT_EN
      cnt_d        = cnt_q;
      rsp_err_d    = rsp_err_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (|req) begin
               grant_id_d = pick;
               mul_a_d    = req_a[{pick, 3'b000} +: 8];
               mul_b_d    = req_b[{pick, 3'b000} +: 8];
               state_d    = StStart;
            end
         end
         StStart: begin
`ifdef MULT_ARB_TIMEOUT_EN
            cnt_d = '0;
`endif
            state_d = StWait;
         end
         StWait: begin
            if (mul_done) begin
               rsp_data_d = mul_c;
`ifdef MULT_ARB_TIMEOUT_EN
               rsp_err_d  = 1'b0;
`endif
               state_d    = StResp;
            end
`ifdef MULT_ARB_TIMEOUT_EN
            // mul_done on the limit cycle takes priority over the abort.
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               rsp_data_d = 8'h00;
               rsp_err_d  = 1'b1;
               state_d    = StResp;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         StResp: begin
            last_grant_d = grant_id_q;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         mul_a_q      <= 8'h00;
         mul_b_q      <= 8'h00;
         rsp_data_q   <= 8'h00;
         grant_id_q   <= '0;
         last_grant_q <= ID_W'(NUM_REQ - 1);
      end else begin
         state_q      <= state_d;
         mul_a_q      <= mul_a_d;
         mul_b_q      <= mul_b_d;
         rsp_data_q   <= rsp_data_d;
         grant_id_q   <= grant_id_d;
         last_grant_q <= last_grant_d;
      end
   end

`ifdef MULT_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   assign rsp_err = rsp_err_q;
`else
   assign rsp_err = 1'b0;
`endif

   always_comb begin
      rsp_valid = '0;
      if (state_q == StResp) begin
         rsp_valid[grant_id_q] = 1'b1;
      end
   end

   assign mul_start = (state_q == StStart);
   assign busy      = (state_q != StIdle);
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign rsp_data  = rsp_data_q;
   assign grant_id  = grant_id_q;

endmodule
